spi_slave_regfile: RTL and testbench
====================================

# spi_slave_regfile

SPI slave register file, downstream of the Wishbone SPI master (`simple_spi_top`) on the serial side. It consumes that master's `sck_o`/`mosi_o` and drives its `miso_i`, in SPI mode 0 (CPOL=0, CPHA=0), MSB first. Frames carry a command byte followed by auto-incrementing data bytes into a 2^ADDR_W x 8 register file. The register file is also visible to local logic through a write-strobe bus and a parallel read port. It serves as the on-chip target and the bench counterpart for the SPI master.

## Interface
- `ADDR_W`, 4: register address width; depth = 2^ADDR_W (legal 1..7).
- `clk_i` in 1: system clock; all logic is on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `ss_n_i` in 1: slave select, active-low; asynchronous to `clk_i`.
- `sck_i` in 1: SPI clock from the master; asynchronous.
- `mosi_i` in 1: serial data in; asynchronous.
- `miso_o` out 1: serial data out.
- `busy_o` out 1: high while a synchronized frame is in progress.
- `wr_stb_o` out 1: one-cycle pulse per committed write.
- `wr_addr_o` out ADDR_W: address of the committed write.
- `wr_dat_o` out 8: data of the committed write.
- `frame_o` out 1: one-cycle pulse at frame end (`ss_n` rise seen).
- `rd_addr_i` in ADDR_W: local read address.
- `rd_dat_o` out 8: `regfile[rd_addr_i]`, registered, 1-cycle latency.

## Operation
- Synchronization:
  - `ss_n_i`, `sck_i` and `mosi_i` each pass through 2 flops.
  - A third flop on `sck` feeds the edge detectors (rise and fall).
  - `mosi` is sampled from its synchronized copy on the `sck` rise.
- Requirement: `clk_i` ≥ 8x `sck` frequency.
- FSM states: IDLE, CMD, WR, RD.
- IDLE:
  - Entered on reset or whenever synchronized `ss_n` is high.
  - Leaves to CMD on the synchronized `ss_n` fall, which also sets `bitcnt`=0 and `miso_o`=0.
- CMD: 8 rising edges shift in the command byte.
  - bit7 = 1 selects write, 0 selects read; bits[ADDR_W-1:0] give the start address. Bits 6..ADDR_W are ignored.
  - On the 8th rise: `addr` is loaded.
  - A read command also preloads `txsr = regfile[addr]` and post-increments `addr`. The FSM then goes to WR or RD.
- WR:
  - On each 8th rise: `regfile[addr] = rxbyte`, `wr_stb_o` pulses with the address and data, and `addr` increments.
  - `miso_o` stays 0.
- RD:
  - On each `sck` fall, `miso_o = txsr[7]` and `txsr` shifts left, so the first data MSB is valid before the next byte's first rise.
  - On each 8th rise: reload `txsr = regfile[addr]` and increment `addr`.
- Address increments wrap modulo 2^ADDR_W.
- `ss_n` rise in any state:
  - Return to IDLE and pulse `frame_o` (only if the frame left IDLE).
  - A partial byte (<8 bits) is discarded, with no write and no strobe.
  - `miso_o` goes to 0.
- `sck` edges while `ss_n` is high are ignored.

## Timing
- Reset values:
  - `regfile` all 0x00, FSM in IDLE, counters 0.
  - `miso_o`, `busy_o`, `wr_stb_o`, `frame_o` = 0.
  - `wr_addr_o`, `wr_dat_o`, `rd_dat_o` = 0.
- Pin-to-action latency is 3 `clk_i` cycles: a raw `sck` rise produces the sample/commit action 3 cycles later. `wr_stb_o` is asserted in that same cycle.
- `miso_o` update latency after a raw `sck` fall is 3 cycles.
- `busy_o` rises 3 cycles after `ss_n_i` falls and drops in the cycle `frame_o` pulses.
- `rd_dat_o` shows a same-cycle SPI write to the same address one cycle later, i.e. write-then-read ordering.
- Reset mid-frame aborts immediately. After release the block waits in IDLE for a fresh `ss_n` fall.

## Configuration
- `SPI_SLAVE_WRPROT_EN`:
  - Defined: address 0 is a read-only ID register that always reads 0xA5. SPI writes to address 0 are dropped with no `wr_stb_o`, but the address still increments.
  - Undefined: address 0 is an ordinary R/W register that resets to 0x00.

## Test plan
- Write burst: frame 0x83,0x11,0x22 -> `wr_stb_o` pulses twice, (3,0x11) then (4,0x22); `rd_addr_i`=4 gives `rd_dat_o`=0x22.
- Read burst: after the writes above, frame 0x03,0x00,0x00 -> `miso_o` shifts out 0x11 then 0x22; 0x00 during the command byte.
- Wrap: with ADDR_W=4, frame 0x8F,0xAA,0xBB -> writes (15,0xAA) then (0,0xBB). With `SPI_SLAVE_WRPROT_EN` the second write is dropped and a read of address 0 returns 0xA5.
- Abort: `ss_n` rises after 5 bits of a write data byte -> no `wr_stb_o`, `frame_o` pulses once, the register is unchanged.
- Reset mid-frame: assert `rst_i` during byte 2 -> all outputs go to 0 and `regfile` to 0x00. The next full frame 0x81,0x5A then writes (1,0x5A).
- Idle immunity: 16 `sck` pulses with `ss_n_i` high -> no strobes, `busy_o`=0, `miso_o`=0.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave fronting a 2^ADDR_W x 8 register file, with a local write-strobe bus and read port.
// Define SPI_SLAVE_WRPROT_EN to make address 0 a read-only ID register (0xA5).
module spi_slave_regfile #(
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ss_n_i,
  input  logic              sck_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              busy_o,
  output logic              wr_stb_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_dat_o,
  output logic              frame_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_dat_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
`ifdef SPI_SLAVE_WRPROT_EN
  localparam bit WRPROT = 1'b1;
`else
  localparam bit WRPROT = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_WR = 2'd2, ST_RD = 2'd3} state_e;

  logic [2:0]        ss_sync_q;
  logic [2:0]        sck_sync_q;
  logic [1:0]        mosi_sync_q;
  logic              ss_fall_s, ss_high_s, sck_rise_s, sck_fall_s, byte_done_s;
  logic [7:0]        rx_byte_s;
  logic [ADDR_W-1:0] cmd_addr_s;

  state_e            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        rxsr_q, rxsr_d, txsr_q, txsr_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [7:0]        wr_dat_q, wr_dat_d, rd_dat_q;
  logic              miso_q, miso_d, busy_q, busy_d, wr_stb_q, wr_stb_d, frame_q, frame_d;
  logic [7:0]        regfile_q [DEPTH];

  function automatic logic [7:0] rf_read(input logic [ADDR_W-1:0] a);
    if (WRPROT && a == ADDR_ZERO) begin
      return 8'hA5;
    end else begin
      return regfile_q[a];
    end
  endfunction

  // ss_n resets low so a select already held low across reset is not mistaken for a fresh fall
  assign ss_fall_s   = ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_high_s   = ss_sync_q[1];
  assign sck_rise_s  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_s  = ~sck_sync_q[1] & sck_sync_q[2];
  assign rx_byte_s   = {rxsr_q[6:0], mosi_sync_q[1]};
  assign byte_done_s = sck_rise_s && (bitcnt_q == 3'd7);
  assign cmd_addr_s  = rx_byte_s[ADDR_W-1:0];
  assign busy_d      = (state_d != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ss_sync_q   <= 3'b000;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], ss_n_i};
      sck_sync_q  <= {sck_sync_q[1:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    rxsr_d    = rxsr_q;
    txsr_d    = txsr_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    frame_d   = 1'b0;
    if (state_q != ST_IDLE && ss_high_s) begin
      state_d = ST_IDLE;
      frame_d = 1'b1;
      miso_d  = 1'b0;
    end else begin
      if (state_q != ST_IDLE && sck_rise_s) begin
        rxsr_d   = rx_byte_s;
        bitcnt_d = bitcnt_q + 3'd1;
      end else begin
        rxsr_d = rxsr_q;
      end
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (ss_fall_s) begin
            state_d  = ST_CMD;
            bitcnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (byte_done_s) begin
            if (rx_byte_s[7]) begin
              addr_d  = cmd_addr_s;
              state_d = ST_WR;
            end else begin
              txsr_d  = rf_read(cmd_addr_s);
              addr_d  = cmd_addr_s + ADDR_ONE;
              state_d = ST_RD;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_WR: begin
          if (byte_done_s) begin
            addr_d = addr_q + ADDR_ONE;
            if (WRPROT && addr_q == ADDR_ZERO) begin
              wr_stb_d = 1'b0;
            end else begin
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_dat_d  = rx_byte_s;
            end
          end else begin
            addr_d = addr_q;
          end
        end
        ST_RD: begin
          if (byte_done_s) begin
            txsr_d = rf_read(addr_q);
            addr_d = addr_q + ADDR_ONE;
          end else if (sck_fall_s) begin
            miso_d = txsr_q[7];
            txsr_d = {txsr_q[6:0], 1'b0};
          end else begin
            txsr_d = txsr_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= 3'd0;
      rxsr_q    <= 8'h00;
      txsr_q    <= 8'h00;
      addr_q    <= ADDR_ZERO;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= ADDR_ZERO;
      wr_dat_q  <= 8'h00;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      rxsr_q    <= rxsr_d;
      txsr_q    <= txsr_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
      frame_q   <= frame_d;
    end
  end

  // Storage and local read port; a read of an address written this cycle returns the new value next cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regfile_q[i] <= 8'h00;
      end
      rd_dat_q <= 8'h00;
    end else begin
      if (wr_stb_d) begin
        regfile_q[wr_addr_d] <= wr_dat_d;
      end
      rd_dat_q <= rf_read(rd_addr_i);
    end
  end

  assign miso_o    = miso_q;
  assign busy_o    = busy_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_dat_o  = wr_dat_q;
  assign frame_o   = frame_q;
  assign rd_dat_o  = rd_dat_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: table of SPI frames plus hand sequences for latency, abort, reset and idle cases.
module tb_spi_slave_regfile;
  localparam int HALF = 8;
`ifdef SPI_SLAVE_WRPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, ss_n, sck, mosi, miso, busy, wr_stb, frame;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_dat, rd_dat;

  spi_slave_regfile #(.ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .ss_n_i(ss_n), .sck_i(sck), .mosi_i(mosi),
    .miso_o(miso), .busy_o(busy), .wr_stb_o(wr_stb), .wr_addr_o(wr_addr),
    .wr_dat_o(wr_dat), .frame_o(frame), .rd_addr_i(rd_addr), .rd_dat_o(rd_dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      cmd;
    int              n;
    logic [2:0][7:0] d;
    logic [2:0][7:0] e;
    logic [3:0]      rda;
    logic [7:0]      rde;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] wr_q[$];
  int          total = 0;
  int          bad = 0;
  int          frame_cnt = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void add_vec(input logic [7:0] cmd, input int n, input logic [7:0] d0, d1, d2,
                                  input logic [7:0] e0, e1, e2, input logic [3:0] rda, input logic [7:0] rde);
    vec_t v;
    v.cmd = cmd; v.n = n; v.d = {d2, d1, d0}; v.e = {e2, e1, e0}; v.rda = rda; v.rde = rde;
    vecs.push_back(v);
  endfunction

  // Scoreboard: each write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && wr_stb) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_stb_unexpected: got addr=%0h dat=%0h expected no strobe", wr_addr, wr_dat);
      end else begin
        check("wr_strobe", 32'({wr_addr, wr_dat}), 32'(wr_q.pop_front()));
      end
    end
    if (!rst && frame) frame_cnt++;
  end

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    repeat (HALF) @(posedge clk); #1;
    sck = 1'b1;
    r = miso;
    repeat (HALF) @(posedge clk); #1;
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    repeat (HALF) @(posedge clk); #1;
  endtask

  task automatic ss_high();
    repeat (HALF) @(posedge clk); #1;
    ss_n = 1'b1;
    repeat (2 * HALF) @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [7:0] e);
    rd_addr = a;
    repeat (2) @(posedge clk); #1;
    check(nm, 32'(rd_dat), 32'(e));
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] a;
    logic [7:0] rx;
    int         fc0;
    fc0 = frame_cnt;
    a = v.cmd[3:0];
    ss_low();
    spi_byte(v.cmd, rx);
    check("cmd_miso", 32'(rx), 32'h0);
    for (int i = 0; i < v.n; i++) begin
      if (v.cmd[7]) begin
        if (!(WP && a == 4'd0)) wr_q.push_back({a, v.d[i]});
        a++;
      end
      spi_byte(v.d[i], rx);
      if (v.cmd[7]) check("wr_miso", 32'(rx), 32'h0);
      else          check("rd_byte", 32'(rx), 32'(v.e[i]));
    end
    ss_high();
    check("frame_once", 32'(frame_cnt), 32'(fc0 + 1));
    check("busy_end", 32'(busy), 32'h0);
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    rd_chk("rd_port", v.rda, v.rde);
  endtask

  initial begin
    logic [7:0] rx, dat;
    logic       r;
    int         fc0;
    vec_t       hv;

    add_vec(8'h83, 2, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 4'd4, 8'h22);
    add_vec(8'h03, 2, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 4'd3, 8'h11);
    add_vec(8'h8F, 2, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 4'd15, 8'hAA);
    add_vec(8'h0F, 2, 8'h00, 8'h00, 8'h00, 8'hAA, WP ? 8'hA5 : 8'hBB, 8'h00, 4'd0, WP ? 8'hA5 : 8'hBB);
    add_vec(8'h87, 2, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 4'd8, 8'hC3);
    add_vec(8'h06, 3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hC3, 4'd7, 8'h5A);
    add_vec(8'h72, 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 4'd3, 8'h11);
    add_vec(8'hF9, 1, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'd9, 8'h99);
    add_vec(8'h08, 3, 8'h00, 8'h00, 8'h00, 8'hC3, 8'h99, 8'h00, 4'd2, 8'h00);

    rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; rd_addr = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stb", 32'(wr_stb), 32'h0);
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_wr_bus", 32'({wr_addr, wr_dat}), 32'h0);
    check("rst_rd_dat", 32'(rd_dat), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    rd_chk("rst_reg0", 4'd0, WP ? 8'hA5 : 8'h00);

    foreach (vecs[k]) run_vec(vecs[k]);

    // busy, strobe and read-port latency around a single write of 0x3C to address 2
    rd_addr = 4'd2;
    fc0 = frame_cnt;
    ss_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("busy_lat2", 32'(busy), 32'h0);
    @(posedge clk); #1;
    check("busy_lat3", 32'(busy), 32'h1);
    repeat (HALF - 3) @(posedge clk); #1;
    spi_byte(8'h82, rx);
    dat = 8'h3C;
    wr_q.push_back({4'd2, dat});
    for (int i = 7; i >= 1; i--) spi_bit(dat[i], r);
    mosi = dat[0];
    repeat (HALF) @(posedge clk); #1;
    sck = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("stb_lat2", 32'(wr_stb), 32'h0);
    @(posedge clk); #1;
    check("stb_lat3", 32'(wr_stb), 32'h1);
    check("rd_old", 32'(rd_dat), 32'h00);
    @(posedge clk); #1;
    check("stb_pulse", 32'(wr_stb), 32'h0);
    check("rd_new", 32'(rd_dat), 32'h3C);
    repeat (HALF - 4) @(posedge clk); #1;
    sck = 1'b0;
    ss_high();
    check("lat_frame", 32'(frame_cnt), 32'(fc0 + 1));

    // abort after 5 data bits: nothing written, then a clean frame to the same address
    fc0 = frame_cnt;
    ss_low();
    spi_byte(8'h85, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
    ss_high();
    check("abort_frame", 32'(frame_cnt), 32'(fc0 + 1));
    check("abort_busy", 32'(busy), 32'h0);
    rd_chk("abort_reg", 4'd5, 8'h00);
    hv.cmd = 8'h85; hv.n = 1; hv.d = {8'h00, 8'h00, 8'h77}; hv.e = '0; hv.rda = 4'd5; hv.rde = 8'h77;
    run_vec(hv);

    // reset in the middle of the second byte
    ss_low();
    spi_byte(8'h8A, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
    fc0 = frame_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_miso", 32'(miso), 32'h0);
    check("mrst_wr_bus", 32'({wr_stb, wr_addr, wr_dat}), 32'h0);
    check("mrst_rd_dat", 32'(rd_dat), 32'h0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("mrst_reg3", 4'd3, 8'h00);
    rd_chk("mrst_reg15", 4'd15, 8'h00);
    ss_n = 1'b1;
    repeat (2 * HALF) @(posedge clk); #1;
    check("mrst_no_frame", 32'(frame_cnt), 32'(fc0));
    hv.cmd = 8'h81; hv.n = 1; hv.d = {8'h00, 8'h00, 8'h5A}; hv.e = '0; hv.rda = 4'd1; hv.rde = 8'h5A;
    run_vec(hv);

    // sck activity while deselected must do nothing
    fc0 = frame_cnt;
    for (int i = 0; i < 16; i++) begin
      spi_bit(1'($urandom_range(0, 1)), r);
      check("idle_miso", 32'(r), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end
    repeat (4) @(posedge clk); #1;
    check("idle_no_frame", 32'(frame_cnt), 32'(fc0));
    rd_chk("idle_reg1", 4'd1, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
